mc_control: RTL
===============

MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 clk  in  1  single clock; all state changes on rising edge.
REQ-002 rst_n  in  1  reset, synchronous, active-low.
REQ-003 Opcode  in  6  instr[31:26] from instruction register, stable from DECODE until the next FETCH.
REQ-004 Funct  in  6  instr[5:0], same stability as Opcode.
REQ-005 Zero  in  1  ALU zero flag (ALUResult==0).
REQ-006 ALUControl  out  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 101 slt, 110 sll.
REQ-007 ALUSrcA  out  2  00 PC, 01 A reg, 10 B reg.
REQ-008 ALUSrcB  out  3  000 B reg, 001 const 4, 010 SignImm, 011 SignImm<<2, 100 ZeroImm, 101 shamt.
REQ-009 PCSrc  out  2  00 ALUResult, 01 ALUOut, 10 jump target.
REQ-010 PCEn  out  1  PC load = PCWrite | (Branch & Zero).
REQ-011 IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite  out  1 each  datapath controls.
REQ-012 Illegal  out  1  one-cycle pulse on an undecodable instruction.
REQ-013 StateDbg  out  4  current state encoding.

Function
REQ-014 The block SHALL be a Moore FSM; all outputs except PCEn SHALL decode from the state register plus Opcode/Funct only.
REQ-015 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, ALUWB, BRANCH, IMMEX, IMMWB, JUMP.
REQ-016 FETCH: IorD=0, IRWrite=1, ALUSrcA=00, ALUSrcB=001, ALUControl=000, PCSrc=00, PCWrite=1; -> DECODE.
REQ-017 DECODE: ALUSrcA=00, ALUSrcB=011, ALUControl=000 (branch target into ALUOut); next by Opcode: 100011/101011 -> MEMADR, 000000 -> RTYPEEX, 000100 -> BRANCH, 001000/001100/001101/001010 -> IMMEX, 000010 -> JUMP, else -> FETCH with Illegal=1.
REQ-018 MEMADR: ALUSrcA=01, ALUSrcB=010, add; lw -> MEMRD, sw -> MEMWR.
REQ-019 MEMRD: IorD=1 -> MEMWB; MEMWB: RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH; MEMWR: IorD=1, MemWrite=1 -> FETCH.
REQ-020 RTYPEEX: ALUSrcA=01, ALUSrcB=000, ALUControl from Funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt); Funct 000000 (sll) SHALL select ALUSrcA=10, ALUSrcB=101, 110; -> ALUWB.
REQ-021 R-type with unlisted Funct SHALL go RTYPEEX -> FETCH with Illegal=1 and no RegWrite.
REQ-022 ALUWB: RegDst=1, MemtoReg=0, RegWrite=1 -> FETCH.
REQ-023 BRANCH: ALUSrcA=01, ALUSrcB=000, sub, PCSrc=01, Branch=1; PCEn=Zero in that cycle -> FETCH.
REQ-024 IMMEX: ALUSrcA=01; addi 010/000, slti 010/101, andi 100/010, ori 100/011 (ALUSrcB/ALUControl); -> IMMWB: RegDst=0, MemtoReg=0, RegWrite=1 -> FETCH.
REQ-025 JUMP: PCSrc=10, PCWrite=1 -> FETCH.
REQ-026 All enables (PCEn, IRWrite, MemWrite, RegWrite) SHALL be 0 in every state not listing them.
REQ-027 Latency in cycles: lw 5, sw 4, R-type 4, immediate 4, beq 3, j 3, illegal 2.

Reset
REQ-028 While rst_n=0 at a rising edge, the state SHALL become FETCH.
REQ-029 While rst_n=0, PCEn, IRWrite, MemWrite, RegWrite and Illegal SHALL be forced 0 regardless of state; other outputs take their FETCH values.
REQ-030 Reset mid-instruction SHALL abandon it; no further write enable SHALL assert for it.

Structure
REQ-031 A shared package mc_pkg SHALL hold the state encoding (4-bit), opcode/funct constants and ALUControl codes.
REQ-032 One combinational sub-module, alu_dec, SHALL map (state class, Opcode, Funct) to ALUControl and an illegal flag.

Verification
REQ-033 Reset low 2 cycles, then high -> StateDbg=FETCH, all enables 0 during reset; IRWrite=1 first cycle after.
REQ-034 Opcode 100011 -> FETCH,DECODE,MEMADR,MEMRD,MEMWB; RegWrite=1 and MemtoReg=1 only in cycle 5.
REQ-035 Opcode 000000, Funct 000000 -> RTYPEEX with ALUSrcA=10, ALUSrcB=101, ALUControl=110; ALUWB RegDst=1.
REQ-036 Opcode 000100 with Zero=1 -> PCEn=1 in BRANCH; repeat with Zero=0 -> PCEn=0; both return to FETCH.
REQ-037 Opcode 111111 -> Illegal=1 for exactly one cycle, back to FETCH, no MemWrite/RegWrite.
REQ-038 rst_n=0 in MEMWR cycle of sw -> MemWrite=0 that cycle; next state FETCH.

Source files
------------

// File: rtl/mc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mc_pkg                                                          |
// | Purpose  : Shared definitions for the multicycle controller: 4-bit state   |
// |            encoding, ALU decode classes, opcode/funct constants, ALU and   |
// |            datapath mux select codes, and the DECODE dispatch function.    |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package mc_pkg;

  localparam int unsigned c_op_w  = 6;
  localparam int unsigned c_alu_w = 3;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_IMMEX   = 4'd9,
    S_IMMWB   = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  // What the ALU is being asked to do in the current state.
  typedef enum logic [1:0] {
    CLS_ADD   = 2'd0,
    CLS_SUB   = 2'd1,
    CLS_RTYPE = 2'd2,
    CLS_IMM   = 2'd3
  } alu_cls_t;

  // Opcodes
  localparam logic [c_op_w-1:0] c_op_rtype = 6'b000000;
  localparam logic [c_op_w-1:0] c_op_lw    = 6'b100011;
  localparam logic [c_op_w-1:0] c_op_sw    = 6'b101011;
  localparam logic [c_op_w-1:0] c_op_beq   = 6'b000100;
  localparam logic [c_op_w-1:0] c_op_j     = 6'b000010;
  localparam logic [c_op_w-1:0] c_op_addi  = 6'b001000;
  localparam logic [c_op_w-1:0] c_op_andi  = 6'b001100;
  localparam logic [c_op_w-1:0] c_op_ori   = 6'b001101;
  localparam logic [c_op_w-1:0] c_op_slti  = 6'b001010;

  // R-type funct codes
  localparam logic [c_op_w-1:0] c_fn_sll = 6'b000000;
  localparam logic [c_op_w-1:0] c_fn_add = 6'b100000;
  localparam logic [c_op_w-1:0] c_fn_sub = 6'b100010;
  localparam logic [c_op_w-1:0] c_fn_and = 6'b100100;
  localparam logic [c_op_w-1:0] c_fn_or  = 6'b100101;
  localparam logic [c_op_w-1:0] c_fn_slt = 6'b101010;

  // ALUControl codes
  localparam logic [c_alu_w-1:0] c_alu_add = 3'b000;
  localparam logic [c_alu_w-1:0] c_alu_sub = 3'b001;
  localparam logic [c_alu_w-1:0] c_alu_and = 3'b010;
  localparam logic [c_alu_w-1:0] c_alu_or  = 3'b011;
  localparam logic [c_alu_w-1:0] c_alu_slt = 3'b101;
  localparam logic [c_alu_w-1:0] c_alu_sll = 3'b110;

  // Datapath mux selects
  localparam logic [1:0] c_srca_pc      = 2'b00;
  localparam logic [1:0] c_srca_a       = 2'b01;
  localparam logic [1:0] c_srca_b       = 2'b10;
  localparam logic [2:0] c_srcb_b       = 3'b000;
  localparam logic [2:0] c_srcb_four    = 3'b001;
  localparam logic [2:0] c_srcb_imm     = 3'b010;
  localparam logic [2:0] c_srcb_imm_sl2 = 3'b011;
  localparam logic [2:0] c_srcb_zimm    = 3'b100;
  localparam logic [2:0] c_srcb_shamt   = 3'b101;
  localparam logic [1:0] c_pcsrc_alu    = 2'b00;
  localparam logic [1:0] c_pcsrc_aluout = 2'b01;
  localparam logic [1:0] c_pcsrc_jump   = 2'b10;

  // State that follows DECODE; S_FETCH doubles as "opcode not decodable".
  function automatic state_t decode_next(input logic [c_op_w-1:0] op);
    state_t nxt;
    case (op)
      c_op_lw, c_op_sw:                        nxt = S_MEMADR;
      c_op_rtype:                              nxt = S_RTYPEEX;
      c_op_beq:                                nxt = S_BRANCH;
      c_op_addi, c_op_andi, c_op_ori, c_op_slti: nxt = S_IMMEX;
      c_op_j:                                  nxt = S_JUMP;
      default:                                 nxt = S_FETCH;
    endcase
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mc_if                                                           |
// | Purpose  : Controller <-> datapath bundle.                                 |
// | Ports    : master - controller: reads Opcode/Funct/Zero, drives controls   |
// |            slave  - datapath : drives Opcode/Funct/Zero, reads controls    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface mc_if;
  import mc_pkg::*;

  logic [c_op_w-1:0]  Opcode;
  logic [c_op_w-1:0]  Funct;
  logic               Zero;
  logic [c_alu_w-1:0] ALUControl;
  logic [1:0]         ALUSrcA;
  logic [2:0]         ALUSrcB;
  logic [1:0]         PCSrc;
  logic               PCEn;
  logic               IorD;
  logic               MemWrite;
  logic               IRWrite;
  logic               RegDst;
  logic               MemtoReg;
  logic               RegWrite;
  logic               Illegal;
  logic [3:0]         StateDbg;

  modport master (
    input  Opcode, Funct, Zero,
    output ALUControl, ALUSrcA, ALUSrcB, PCSrc, PCEn, IorD, MemWrite,
           IRWrite, RegDst, MemtoReg, RegWrite, Illegal, StateDbg
  );

  modport slave (
    output Opcode, Funct, Zero,
    input  ALUControl, ALUSrcA, ALUSrcB, PCSrc, PCEn, IorD, MemWrite,
           IRWrite, RegDst, MemtoReg, RegWrite, Illegal, StateDbg
  );
endinterface
`default_nettype wire

// File: rtl/alu_dec.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_dec                                                         |
// | Purpose  : Combinational ALU operation decoder.                            |
// | Ports    : i_cls         - ALU class of the current state                  |
// |            i_opcode      - instruction opcode (immediate ops)              |
// |            i_funct       - instruction funct (R-type ops)                  |
// |            o_alu_control - ALUControl code                                 |
// |            o_illegal     - class/opcode/funct combination not decodable    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module alu_dec
  import mc_pkg::*;
(
  input  alu_cls_t           i_cls,
  input  logic [c_op_w-1:0]  i_opcode,
  input  logic [c_op_w-1:0]  i_funct,
  output logic [c_alu_w-1:0] o_alu_control,
  output logic               o_illegal
);

  always_comb begin
    o_alu_control = c_alu_add;
    o_illegal     = 1'b0;
    case (i_cls)
      CLS_SUB: o_alu_control = c_alu_sub;
      CLS_RTYPE: begin
        case (i_funct)
          c_fn_add: o_alu_control = c_alu_add;
          c_fn_sub: o_alu_control = c_alu_sub;
          c_fn_and: o_alu_control = c_alu_and;
          c_fn_or:  o_alu_control = c_alu_or;
          c_fn_slt: o_alu_control = c_alu_slt;
          c_fn_sll: o_alu_control = c_alu_sll;
          default:  o_illegal     = 1'b1;
        endcase
      end
      CLS_IMM: begin
        case (i_opcode)
          c_op_addi: o_alu_control = c_alu_add;
          c_op_slti: o_alu_control = c_alu_slt;
          c_op_andi: o_alu_control = c_alu_and;
          c_op_ori:  o_alu_control = c_alu_or;
          default:   o_illegal     = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mc_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mc_control                                                      |
// | Purpose  : Moore-style multicycle MIPS controller (lw/sw/R-type/beq/j/imm). |
// | Ports    : clk   - clock, state changes on rising edge                     |
// |            rst_n - synchronous active-low reset                            |
// |            ctl   - mc_if.master: Opcode/Funct/Zero in, datapath controls,  |
// |                    PCEn, Illegal and StateDbg out                          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mc_control
  import mc_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  mc_if.master  ctl
);

  state_t             r_state;
  state_t             w_state;
  alu_cls_t           w_cls;
  logic [c_alu_w-1:0] w_alu_ctl;
  logic               w_alu_illegal;
  logic [1:0]         w_srca;
  logic [2:0]         w_srcb;
  logic [1:0]         w_pcsrc;
  logic               w_iord, w_regdst, w_memtoreg;
  logic               w_pc_write, w_branch, w_irwrite, w_memwrite, w_regwrite, w_illegal;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:   r_state <= S_DECODE;
        S_DECODE:  r_state <= decode_next(ctl.Opcode);
        S_MEMADR:  r_state <= (ctl.Opcode == c_op_sw) ? S_MEMWR : S_MEMRD;
        S_MEMRD:   r_state <= S_MEMWB;
        S_RTYPEEX: r_state <= w_alu_illegal ? S_FETCH : S_ALUWB;
        S_IMMEX:   r_state <= S_IMMWB;
        default:   r_state <= S_FETCH;
      endcase
    end
  end

  // Outputs are decoded from this view of the state: while reset is held,
  // the controller looks like FETCH regardless of the register's content.
  assign w_state = rst_n ? r_state : S_FETCH;

  always_comb begin
    w_cls = CLS_ADD;
    case (w_state)
      S_BRANCH:  w_cls = CLS_SUB;
      S_RTYPEEX: w_cls = CLS_RTYPE;
      S_IMMEX:   w_cls = CLS_IMM;
      default: ;
    endcase
  end

  alu_dec u_alu_dec (
    .i_cls         (w_cls),
    .i_opcode      (ctl.Opcode),
    .i_funct       (ctl.Funct),
    .o_alu_control (w_alu_ctl),
    .o_illegal     (w_alu_illegal)
  );

  always_comb begin
    w_srca     = c_srca_pc;
    w_srcb     = c_srcb_b;
    w_pcsrc    = c_pcsrc_alu;
    w_iord     = 1'b0;
    w_regdst   = 1'b0;
    w_memtoreg = 1'b0;
    w_pc_write = 1'b0;
    w_branch   = 1'b0;
    w_irwrite  = 1'b0;
    w_memwrite = 1'b0;
    w_regwrite = 1'b0;
    w_illegal  = 1'b0;
    case (w_state)
      S_FETCH: begin
        w_srcb     = c_srcb_four;
        w_irwrite  = 1'b1;
        w_pc_write = 1'b1;
      end
      S_DECODE: begin
        w_srcb    = c_srcb_imm_sl2;
        w_illegal = (decode_next(ctl.Opcode) == S_FETCH);
      end
      S_MEMADR: begin
        w_srca = c_srca_a;
        w_srcb = c_srcb_imm;
      end
      S_MEMRD: w_iord = 1'b1;
      S_MEMWB: begin
        w_memtoreg = 1'b1;
        w_regwrite = 1'b1;
      end
      S_MEMWR: begin
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        // sll shifts the B register by shamt rather than combining A and B.
        if (ctl.Funct == c_fn_sll) begin
          w_srca = c_srca_b;
          w_srcb = c_srcb_shamt;
        end else begin
          w_srca = c_srca_a;
        end
        w_illegal = w_alu_illegal;
      end
      S_ALUWB: begin
        w_regdst   = 1'b1;
        w_regwrite = 1'b1;
      end
      S_BRANCH: begin
        w_srca   = c_srca_a;
        w_pcsrc  = c_pcsrc_aluout;
        w_branch = 1'b1;
      end
      S_IMMEX: begin
        w_srca = c_srca_a;
        w_srcb = (ctl.Opcode == c_op_andi || ctl.Opcode == c_op_ori) ? c_srcb_zimm : c_srcb_imm;
      end
      S_IMMWB: w_regwrite = 1'b1;
      S_JUMP: begin
        w_pcsrc    = c_pcsrc_jump;
        w_pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign ctl.ALUControl = w_alu_ctl;
  assign ctl.ALUSrcA    = w_srca;
  assign ctl.ALUSrcB    = w_srcb;
  assign ctl.PCSrc      = w_pcsrc;
  assign ctl.IorD       = w_iord;
  assign ctl.RegDst     = w_regdst;
  assign ctl.MemtoReg   = w_memtoreg;
  assign ctl.StateDbg   = w_state;
  // Enables are additionally qualified by rst_n so that a reset arriving
  // mid-cycle kills the write of an in-flight instruction immediately.
  assign ctl.PCEn       = rst_n & (w_pc_write | (w_branch & ctl.Zero));
  assign ctl.IRWrite    = rst_n & w_irwrite;
  assign ctl.MemWrite   = rst_n & w_memwrite;
  assign ctl.RegWrite   = rst_n & w_regwrite;
  assign ctl.Illegal    = rst_n & w_illegal;

endmodule
`default_nettype wire
